// File: rtl/disp_timing_if.sv
// Parallel display bus between a timing source and the receive front end.
// Carries raw sync/data pins plus recovered pixel strobe and timing status.
interface disp_timing_if #(
    parameter int RGB_W = 24
);
    logic             Disp_Hs;
    logic             Disp_Vs;
    logic             Disp_De;
    logic [RGB_W-1:0] Disp_Data;
    logic             Pix_Valid;
    logic [RGB_W-1:0] Pix_Data;
    logic [11:0]      H_Addr;
    logic [11:0]      V_Addr;
    logic             Frame_Begin;
    logic             Line_Begin;
    logic [11:0]      H_Total;
    logic [11:0]      H_Active;
    logic [11:0]      V_Total;
    logic [11:0]      V_Active;
    logic             Locked;
    logic             Fmt_Err;

    modport master (
        output Disp_Hs, Disp_Vs, Disp_De, Disp_Data,
        input  Pix_Valid, Pix_Data, H_Addr, V_Addr,
        input  Frame_Begin, Line_Begin,
        input  H_Total, H_Active, V_Total, V_Active,
        input  Locked, Fmt_Err
    );

    modport slave (
        input  Disp_Hs, Disp_Vs, Disp_De, Disp_Data,
        output Pix_Valid, Pix_Data, H_Addr, V_Addr,
        output Frame_Begin, Line_Begin,
        output H_Total, H_Active, V_Total, V_Active,
        output Locked, Fmt_Err
    );
endinterface

// File: rtl/disp_timing_rx.sv
// Display timing receiver: recovers pixel coordinates, measures frame
// geometry and tracks timing lock across consecutive frames.
module disp_timing_rx #(
    parameter int RGB_W       = 24,
    parameter int LOCK_FRAMES = 2,
    parameter bit GATE_UNLOCK = 1'b1
) (
    input logic         clk_disp,
    input logic         rst_n,
    disp_timing_if.slave bus
);
    localparam logic [1:0]  ST_UNLOCKED = 2'd0;
    localparam logic [1:0]  ST_CHECK    = 2'd1;
    localparam logic [1:0]  ST_LOCKED   = 2'd2;
    localparam logic [11:0] CNT_MAX     = 12'hFFF;
    localparam logic [3:0]  LOCK_N      = 4'(LOCK_FRAMES);

    logic             s1_hs, s1_vs, s1_de;
    logic [RGB_W-1:0] s1_data;
    logic             p_hs, p_vs, p_de;
    logic             ok1, ok2;
    logic             hs_rise, vs_rise, de_fall;

    logic [11:0] hcnt, hact, lines, rows;
    logic [11:0] last_htot, last_hact;
    logic [11:0] hcnt_inc, htot_now, vtot_now;

    logic [1:0]  state, state_nxt;
    logic [3:0]  match_cnt, match_nxt, match_inc;
    logic        match, timeout, err_nxt, pix_ok;

    logic             pix_valid, frame_begin, line_begin;
    logic             locked, fmt_err;
    logic [RGB_W-1:0] pix_data;
    logic [11:0]      h_addr, v_addr;
    logic [11:0]      h_total, h_active, v_total, v_active;

    always_ff @(posedge clk_disp) begin
        if (!rst_n) begin
            s1_hs   <= 1'b0;
            s1_vs   <= 1'b0;
            s1_de   <= 1'b0;
            s1_data <= '0;
            p_hs    <= 1'b0;
            p_vs    <= 1'b0;
            p_de    <= 1'b0;
            ok1     <= 1'b0;
            ok2     <= 1'b0;
        end else begin
            s1_hs   <= bus.Disp_Hs;
            s1_vs   <= bus.Disp_Vs;
            s1_de   <= bus.Disp_De;
            s1_data <= bus.Disp_Data;
            p_hs    <= s1_hs;
            p_vs    <= s1_vs;
            p_de    <= s1_de;
            ok1     <= 1'b1;
            ok2     <= ok1;
        end
    end

    // Edges only count once the previous-sample register holds real pin data
    assign hs_rise = ok2 & s1_hs & ~p_hs;
    assign vs_rise = ok2 & s1_vs & ~p_vs;
    assign de_fall = ok2 & ~s1_de & p_de;

    assign hcnt_inc  = (hcnt == CNT_MAX) ? CNT_MAX : hcnt + 12'd1;
    assign htot_now  = hs_rise ? hcnt_inc : last_htot;
    assign vtot_now  = hs_rise ? lines + 12'd1 : lines;
    assign match_inc = match_cnt + 4'd1;
    assign timeout   = (hcnt == CNT_MAX - 12'd1) & ~hs_rise;
    assign pix_ok    = s1_de & (locked | ~GATE_UNLOCK);

    assign match = (htot_now == h_total) && (last_hact == h_active) &&
                   (vtot_now == v_total) && (rows == v_active);

    always_comb begin
        state_nxt = state;
        match_nxt = match_cnt;
        err_nxt   = 1'b0;
        if (timeout) begin
            state_nxt = ST_UNLOCKED;
            match_nxt = 4'd0;
            err_nxt   = (state == ST_LOCKED);
        end else if (vs_rise) begin
            case (state)
                ST_UNLOCKED: begin
                    state_nxt = ST_CHECK;
                    match_nxt = 4'd0;
                end
                ST_CHECK: begin
                    if (!match) begin
                        match_nxt = 4'd0;
                    end else if (match_inc >= LOCK_N) begin
                        state_nxt = ST_LOCKED;
                        match_nxt = 4'd0;
                    end else begin
                        match_nxt = match_inc;
                    end
                end
                ST_LOCKED: begin
                    if (!match) begin
                        state_nxt = ST_UNLOCKED;
                        err_nxt   = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_UNLOCKED;
                    match_nxt = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_disp) begin
        if (!rst_n) begin
            hcnt      <= '0;
            hact      <= '0;
            lines     <= '0;
            rows      <= '0;
            last_htot <= '0;
            last_hact <= '0;
            state     <= ST_UNLOCKED;
            match_cnt <= '0;
        end else begin
            hcnt      <= hs_rise ? 12'd0 : hcnt_inc;
            state     <= state_nxt;
            match_cnt <= match_nxt;
            if (hs_rise)
                last_htot <= hcnt_inc;
            if (hs_rise)
                hact <= {11'd0, s1_de};
            else if (s1_de && hact != CNT_MAX)
                hact <= hact + 12'd1;
            if (de_fall)
                last_hact <= hact;
            if (vs_rise)
                lines <= 12'd0;
            else if (hs_rise)
                lines <= lines + 12'd1;
            if (vs_rise)
                rows <= 12'd0;
            else if (de_fall)
                rows <= rows + 12'd1;
        end
    end

    always_ff @(posedge clk_disp) begin
        if (!rst_n) begin
            pix_valid   <= 1'b0;
            pix_data    <= '0;
            h_addr      <= '0;
            v_addr      <= '0;
            frame_begin <= 1'b0;
            line_begin  <= 1'b0;
            h_total     <= '0;
            h_active    <= '0;
            v_total     <= '0;
            v_active    <= '0;
            locked      <= 1'b0;
            fmt_err     <= 1'b0;
        end else begin
            pix_valid   <= pix_ok;
            pix_data    <= pix_ok ? s1_data : '0;
            h_addr      <= (s1_de && !hs_rise) ? hact : 12'd0;
            v_addr      <= (s1_de && !vs_rise) ? rows : 12'd0;
            frame_begin <= vs_rise;
            line_begin  <= hs_rise;
            locked      <= (state_nxt == ST_LOCKED);
            fmt_err     <= err_nxt;
            if (vs_rise) begin
                h_total  <= htot_now;
                h_active <= last_hact;
                v_total  <= vtot_now;
                v_active <= rows;
            end
        end
    end

    assign bus.Pix_Valid   = pix_valid;
    assign bus.Pix_Data    = pix_data;
    assign bus.H_Addr      = h_addr;
    assign bus.V_Addr      = v_addr;
    assign bus.Frame_Begin = frame_begin;
    assign bus.Line_Begin  = line_begin;
    assign bus.H_Total     = h_total;
    assign bus.H_Active    = h_active;
    assign bus.V_Total     = v_total;
    assign bus.V_Active    = v_active;
    assign bus.Locked      = locked;
    assign bus.Fmt_Err     = fmt_err;
endmodule
